// File: rtl/core_pkg.sv
// Shared core definitions: fetch sequencer states, halt encoding, reset PC, datapath width.
package core_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned RETIRE_W = 64;

    localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_HALT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_HALT
    } state_t;

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns the PC, drives the imem port,
// presents one instruction at a time and gates regfile writes to the commit cycle.
module fetch_seq_ctrl
    import core_pkg::state_t, core_pkg::ST_IDLE, core_pkg::ST_REQ, core_pkg::ST_WAIT,
           core_pkg::ST_EXEC, core_pkg::ST_HALT, core_pkg::INST_HALT;
#(
    parameter int unsigned      XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(core_pkg::RESET_PC),
    parameter int unsigned      RETIRE_W = core_pkg::RETIRE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    output logic                exec_valid,
    output logic [31:0]         exec_inst,
    output logic [XLEN-1:0]     exec_pc,
    input  logic                exec_done,
    input  logic                exec_br_taken,
    input  logic [XLEN-1:0]     exec_br_target,
    output logic                rf_we_gate,
    output logic                halted,
    output logic                err_misalign,
    output logic [RETIRE_W-1:0] retire_cnt
);

    state_t              state, state_next;
    logic [XLEN-1:0]     pc, pc_next;
    logic [31:0]         inst_next;
    logic [XLEN-1:0]     epc_next;
    logic [RETIRE_W-1:0] retire_next;
    logic                err_next;

    // The fetch address is the architectural PC itself.
    assign imem_req_addr = pc;

    // State, PC, latched instruction, counters and state-decoded handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            exec_inst      <= '0;
            exec_pc        <= '0;
            retire_cnt     <= '0;
            err_misalign   <= 1'b0;
            imem_req_valid <= 1'b0;
            exec_valid     <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            exec_inst      <= inst_next;
            exec_pc        <= epc_next;
            retire_cnt     <= retire_next;
            err_misalign   <= err_next;
            imem_req_valid <= (state_next == ST_REQ);
            exec_valid     <= (state_next == ST_EXEC);
            halted         <= (state_next == ST_HALT);
        end
    end

    // Next-state logic; rf_we_gate is combinational so it lines up with exec_done.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        inst_next   = exec_inst;
        epc_next    = exec_pc;
        retire_next = retire_cnt;
        err_next    = err_misalign;
        rf_we_gate  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_REQ;
                end
            end

            ST_REQ: begin
                if (imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_resp_valid) begin
                    inst_next = imem_resp_data;
                    epc_next  = pc;
                    if (imem_resp_data == INST_HALT) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (exec_done) begin
                    rf_we_gate  = 1'b1;
                    retire_next = retire_cnt + RETIRE_W'(1);
                    // A word-misaligned redirect still writes the link, then stops the core.
                    if (exec_br_taken && exec_br_target[1]) begin
                        err_next   = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = exec_br_taken ? exec_br_target : pc + XLEN'(4);
                        state_next = ST_REQ;
                    end
                end
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: transaction-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        exec_valid;
    logic [31:0] exec_inst;
    logic [63:0] exec_pc;
    logic        exec_done;
    logic        exec_br_taken;
    logic [63:0] exec_br_target;
    logic        rf_we_gate;
    logic        halted;
    logic        err_misalign;
    logic [63:0] retire_cnt;

    fetch_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .exec_valid     (exec_valid),
        .exec_inst      (exec_inst),
        .exec_pc        (exec_pc),
        .exec_done      (exec_done),
        .exec_br_taken  (exec_br_taken),
        .exec_br_target (exec_br_target),
        .rf_we_gate     (rf_we_gate),
        .halted         (halted),
        .err_misalign   (err_misalign),
        .retire_cnt     (retire_cnt)
    );

    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus knobs
    int          stall     = 0;
    logic        late_resp = 1'b0;
    logic        br_en     = 1'b0;
    logic [63:0] br_pc     = '0;
    logic [63:0] br_tgt    = '0;
    logic        halt_en   = 1'b0;
    logic [63:0] halt_addr = '0;
    logic        noise     = 1'b0;

    // Observation logs
    logic [63:0] acc_log[$];
    int          pulses = 0;

    // Model state
    logic        m_started    = 1'b0;
    logic        m_req        = 1'b0;
    logic        m_wait       = 1'b0;
    logic        m_inst_valid = 1'b0;
    logic [63:0] m_pc         = PC0;
    logic [31:0] m_inst       = '0;
    logic [63:0] m_epc        = '0;
    logic [63:0] m_retire     = '0;
    logic        m_halted     = 1'b0;
    logic        m_err        = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        if (halt_en && a == halt_addr) return 32'h0;
        return {a[21:2], 12'h093};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [63:0] exp);
        logic [63:0] v;
        v = (idx < acc_log.size()) ? acc_log[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
        chk(name, v, exp);
    endtask

    // Memory and execute-stage responder: memory answers one cycle after acceptance.
    initial begin
        logic        acc;
        logic [63:0] acc_addr;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        exec_done       = 1'b0;
        exec_br_taken   = 1'b0;
        exec_br_target  = '0;
        forever begin
            @(posedge clk);
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            #1;
            imem_resp_valid = acc || late_resp;
            imem_resp_data  = mem_data(acc_addr);
            if (imem_req_valid && stall > 0) begin
                imem_req_ready = 1'b0;
                stall--;
            end else begin
                imem_req_ready = 1'b1;
            end
            noise          = ~noise;
            exec_done      = exec_valid | noise;
            exec_br_taken  = br_en && exec_valid && exec_pc == br_pc;
            exec_br_target = br_tgt;
        end
    end

    // Log accepted fetch addresses and write-gate pulses.
    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
        if (rf_we_gate) pulses++;
    end

    // Instruction-level model: fetch, wait for data, execute, commit, redirect or halt.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started    <= 1'b0;
            m_req        <= 1'b0;
            m_wait       <= 1'b0;
            m_inst_valid <= 1'b0;
            m_pc         <= PC0;
            m_inst       <= '0;
            m_retire     <= '0;
            m_halted     <= 1'b0;
            m_err        <= 1'b0;
        end else if (!m_halted) begin
            if (!m_started) begin
                if (start) begin
                    m_started <= 1'b1;
                    m_req     <= 1'b1;
                end
            end else if (m_req) begin
                if (imem_req_ready) begin
                    m_req  <= 1'b0;
                    m_wait <= 1'b1;
                end
            end else if (m_wait) begin
                if (imem_resp_valid) begin
                    m_wait <= 1'b0;
                    if (imem_resp_data == 32'h0) begin
                        m_halted <= 1'b1;
                    end else begin
                        m_inst_valid <= 1'b1;
                        m_inst       <= imem_resp_data;
                        m_epc        <= m_pc;
                    end
                end
            end else if (m_inst_valid && exec_done) begin
                m_inst_valid <= 1'b0;
                m_retire     <= m_retire + 64'd1;
                if (exec_br_taken && exec_br_target[1]) begin
                    m_halted <= 1'b1;
                    m_err    <= 1'b1;
                end else begin
                    m_pc  <= exec_br_taken ? exec_br_target : m_pc + 64'd4;
                    m_req <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("req_valid", {63'b0, imem_req_valid}, {63'b0, m_req});
            if (m_req) chk("req_addr", imem_req_addr, m_pc);
            chk("exec_valid", {63'b0, exec_valid}, {63'b0, m_inst_valid});
            if (m_inst_valid) begin
                chk("exec_inst", {32'b0, exec_inst}, {32'b0, m_inst});
                chk("exec_pc", exec_pc, m_epc);
            end
            chk("rf_we_gate", {63'b0, rf_we_gate}, {63'b0, m_inst_valid && exec_done});
            chk("retire_cnt", retire_cnt, m_retire);
            chk("halted", {63'b0, halted}, {63'b0, m_halted});
            chk("err_misalign", {63'b0, err_misalign}, {63'b0, m_err});
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        late_resp = 1'b0;
        stall     = 0;
        br_en     = 1'b0;
        halt_en   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        acc_log.delete();
        pulses = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;

        // Straight-line fetch with zero-wait memory
        do_reset();
        chk("rst_retire", retire_cnt, 64'd0);
        chk("rst_inst", {32'b0, exec_inst}, 64'd0);
        chk("rst_addr", imem_req_addr, PC0);
        chk("rst_flags", {60'b0, imem_req_valid, exec_valid, halted, err_misalign}, 64'd0);
        start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("seq_retire3", retire_cnt, 64'd3);
        chk("seq_pulses", 64'(pulses), 64'd3);
        chk_log("seq_addr0", 0, 64'h8000_0000);
        chk_log("seq_addr1", 1, 64'h8000_0004);
        chk_log("seq_addr2", 2, 64'h8000_0008);

        // Request stalled by memory for five cycles
        do_reset();
        stall = 5;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'b0, imem_req_valid}, 64'd1);
            chk("stall_addr", imem_req_addr, PC0);
            chk("stall_exec", {63'b0, exec_valid}, 64'd0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_nacc", 64'(acc_log.size()), 64'd1);
        chk_log("stall_addr0", 0, PC0);

        // Taken branch redirect
        do_reset();
        br_en  = 1'b1;
        br_pc  = 64'h8000_0004;
        br_tgt = 64'h8000_0100;
        start  = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk_log("br_addr2", 2, 64'h8000_0100);
        chk_log("br_addr3", 3, 64'h8000_0104);
        chk("br_retire", retire_cnt, 64'd3);

        // Misaligned redirect target
        do_reset();
        br_en  = 1'b1;
        br_pc  = PC0;
        br_tgt = 64'h8000_0102;
        start  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mis_halted", {63'b0, halted}, 64'd1);
        chk("mis_err", {63'b0, err_misalign}, 64'd1);
        chk("mis_retire", retire_cnt, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2 start = ~start;
        end
        @(negedge clk);
        chk("mis_pulses", 64'(pulses), 64'd1);
        chk("mis_nacc", 64'(acc_log.size()), 64'd1);
        chk("mis_still", {62'b0, halted, imem_req_valid}, 64'd2);

        // Halt instruction after two retires
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 64'h8000_0008;
        start     = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            if (i > 0) #2 start = ~start;
        end
        @(negedge clk);
        chk("hlt_halted", {63'b0, halted}, 64'd1);
        chk("hlt_err", {63'b0, err_misalign}, 64'd0);
        chk("hlt_retire", retire_cnt, 64'd2);
        chk("hlt_pulses", 64'(pulses), 64'd2);
        chk("hlt_nacc", 64'(acc_log.size()), 64'd3);

        // Asynchronous reset while waiting for the fetch response
        do_reset();
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("arst_flags", {59'b0, imem_req_valid, exec_valid, halted, err_misalign, rf_we_gate}, 64'd0);
        chk("arst_addr", imem_req_addr, PC0);
        chk("arst_retire", retire_cnt, 64'd0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        late_resp = 1'b1;
        @(posedge clk);
        #2;
        late_resp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("late_exec", {63'b0, exec_valid}, 64'd0);
        chk("late_req", {63'b0, imem_req_valid}, 64'd0);
        acc_log.delete();
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_log("restart_addr", 0, PC0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64 single-issue execute datapath.
- Owns the PC and drives a valid/ready instruction-memory port.
- Presents one instruction at a time to the execute stage and gates register-file writes to a single commit cycle.
- Handles jal/jalr redirects and halts on the all-zero instruction.
- Replaces the free-running per-clock PC update of the current core.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
- XLEN, 64, PC/target width
- RETIRE_W, 64, retired-instruction counter width

Ports:
- clk  in  1  clock, posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; leave IDLE and begin fetching
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid  in  1  fetch data valid
- imem_resp_data  in  32  fetched instruction
- exec_valid  out  1  exec_inst/exec_pc valid to execute stage
- exec_inst  out  32  latched instruction
- exec_pc  out  XLEN  PC of exec_inst
- exec_done  in  1  execute stage result ready (may be same cycle as exec_valid)
- exec_br_taken  in  1  jal/jalr taken, sampled with exec_done
- exec_br_target  in  XLEN  redirect target, bit0 already cleared
- rf_we_gate  out  1  AND-ed into regfile we; high only in commit cycle
- halted  out  1  sticky halt indication
- err_misalign  out  1  sticky; halt caused by target[1]==1
- retire_cnt  out  RETIRE_W  committed instructions

Behaviour:
- Reset values (async, rst_n low): state=IDLE, pc=RESET_PC, exec_inst=0, retire_cnt=0; every 1-bit output 0.
- States: IDLE, REQ, WAIT, EXEC, HALT.
- IDLE:
  - All handshake outputs 0.
  - start=1 -> REQ next cycle.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Hold both stable until imem_req_ready=1; that cycle transfers -> WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: latch exec_inst=imem_resp_data, exec_pc=pc.
  - If data==32'h0 -> HALT (no commit, no retire); else -> EXEC.
  - A response arriving in the same cycle the request is accepted is not legal and is ignored.
- EXEC:
  - exec_valid=1; exec_inst/exec_pc stable.
  - Commit cycle = EXEC && exec_done. In that cycle:
    - rf_we_gate=1.
    - retire_cnt += 1 (wraps modulo 2^RETIRE_W).
    - next pc = exec_br_taken ? exec_br_target : pc+4, computed mod 2^XLEN.
  - Next state -> REQ, so minimum 3 cycles per instruction with zero-wait memory.
- Misaligned redirect:
  - Condition: exec_br_taken && exec_br_target[1]==1.
  - Still a commit: rf_we_gate=1 (link written), retire counts.
  - pc not updated; err_misalign<=1; -> HALT.
- HALT:
  - Terminal. halted=1; all handshakes 0; ignores start.
  - Only rst_n exits.
- rf_we_gate=0 in every state except the commit cycle, so no spurious writes during fetch stalls.
- Reset mid-operation: immediate return to reset values. An outstanding imem response after reset is ignored because the block is in IDLE.
- exec_done outside EXEC: ignored.

Decomposition:
- Shared package (core_pkg):
  - state enum (IDLE, REQ, WAIT, EXEC, HALT).
  - INST_HALT = 32'h0.
  - RESET_PC default.
  - XLEN. The core, regfile and this block already share XLEN.
- No sub-module needed. The FSM, PC register and retire counter live in one module; the PC incrementer stays inline.

Test Plan:
- Reset with RESET_PC default, start=1, zero-wait memory returning addi at every address -> requests at 0x80000000, 0x80000004, 0x80000008; one rf_we_gate pulse per instruction; retire_cnt=3 after 9 post-start cycles.
- imem_req_ready held low 5 cycles -> imem_req_valid and addr 0x80000000 stable all 5 cycles; no exec_valid until the response.
- Commit with exec_br_taken=1, target=0x80000100 -> next imem_req_addr=0x80000100.
- Commit with target=0x80000102 -> rf_we_gate pulses; halted=1 and err_misalign=1 next cycle; retire_cnt increments; no further requests.
- Response data 32'h0 after 2 retired instructions -> halted=1, rf_we_gate never high for it, retire_cnt stays 2; start toggling has no effect.
- rst_n asserted low while in WAIT -> outputs 0 and pc=RESET_PC asynchronously; a late imem_resp_valid is ignored; restart fetches 0x80000000.
